// File: rtl/gpio_pad_ctrl.sv
// Core-side GPIO pad controller: APB register file, pad direction/config and
// output data, two-flop input synchroniser, edge detection and level interrupt.
module gpio_pad_ctrl #(
    parameter int N_PINS        = 8,   // 1..32
    parameter int CONF_WIDTH    = 3,   // >= 2: bit 0 direction, upper bits from PADCFG
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                         clk_in,
    input  logic                         reset_int,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [4:0]                   paddr,
    input  logic [31:0]                  pwdata,
    output logic [31:0]                  prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [N_PINS*CONF_WIDTH-1:0] pad_cfg_out,
    output logic [N_PINS-1:0]            pad_data_out,
    input  logic [N_PINS-1:0]            pad_data_in,
    output logic                         irq_out
);

    localparam int PW = CONF_WIDTH - 1;
    localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        OFF_DIR     = 3'd0,
        OFF_DOUT    = 3'd1,
        OFF_DIN     = 3'd2,
        OFF_RISE_EN = 3'd3,
        OFF_FALL_EN = 3'd4,
        OFF_STATUS  = 3'd5,
        OFF_PADCFG  = 3'd6,
        OFF_NONE    = 3'd7
    } reg_off_e;

    logic [N_PINS-1:0] dir_q, dir_d;
    logic [N_PINS-1:0] dout_q, dout_d;
    logic [N_PINS-1:0] rise_en_q, rise_en_d;
    logic [N_PINS-1:0] fall_en_q, fall_en_d;
    logic [N_PINS-1:0] status_q, status_d;
    logic [N_PINS-1:0] sync1_q, sync1_d;
    logic [N_PINS-1:0] sync2_q, sync2_d;
    logic [N_PINS-1:0] hist_q, hist_d;
    logic [PW-1:0]     padcfg_q, padcfg_d;
    logic [SW-1:0]     settle_q [N_PINS];
    logic [SW-1:0]     settle_d [N_PINS];
    logic              irq_q, irq_d;

    reg_off_e          off;
    logic              access;
    logic              err;
    logic              wr_en;
    logic [N_PINS-1:0] wdata;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] qual;
    logic [N_PINS-1:0] set_mask;
    logic [N_PINS-1:0] clr_mask;
    logic [31:0]       rd_word;
    logic              unused_apb_bits;

    assign off    = reg_off_e'(paddr[4:2]);
    assign access = psel & penable;
    assign err    = access & ((off == OFF_NONE) | (pwrite & (off == OFF_DIN)));
    assign wr_en  = access & pwrite & ~err;
    assign wdata  = pwdata[N_PINS-1:0];
    assign rise   = sync2_q & ~hist_q;
    assign fall   = ~sync2_q & hist_q;

    assign unused_apb_bits = ^{paddr[1:0], pwdata};

    genvar gi;
    generate
        for (gi = 0; gi < N_PINS; gi++) begin : g_pin
            // Edges only count on a settled input pin.
            assign qual[gi] = ~dir_q[gi] & (settle_q[gi] == '0);
            assign pad_cfg_out[gi*CONF_WIDTH +: CONF_WIDTH] = {padcfg_q, ~dir_q[gi]};
        end
    endgenerate

    always_comb begin
        dir_d     = dir_q;
        dout_d    = dout_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        padcfg_d  = padcfg_q;
        clr_mask  = '0;
        if (wr_en) begin
            case (off)
                OFF_DIR:     dir_d     = wdata;
                OFF_DOUT:    dout_d    = wdata;
                OFF_RISE_EN: rise_en_d = wdata;
                OFF_FALL_EN: fall_en_d = wdata;
                OFF_STATUS:  clr_mask  = wdata;
                OFF_PADCFG:  padcfg_d  = pwdata[PW-1:0];
                default:     ;
            endcase
        end

        sync1_d = pad_data_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;

        // A new edge in the same cycle as a W1C clear keeps the bit set.
        set_mask = ((rise & rise_en_q) | (fall & fall_en_q)) & qual;
        status_d = (status_q & ~clr_mask) | set_mask;

        // Interrupt follows STATUS one cycle later.
        irq_d = |status_q;

        // Holding the count while the pin drives also covers the reload on a
        // 1->0 DIR write; writes that keep a pin as input leave it running.
        for (int i = 0; i < N_PINS; i++) begin
            settle_d[i] = settle_q[i];
            if (dir_q[i]) begin
                settle_d[i] = SETTLE_LOAD;
            end else if (settle_q[i] != '0) begin
                settle_d[i] = settle_q[i] - SW'(1);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (off)
            OFF_DIR:     rd_word[N_PINS-1:0] = dir_q;
            OFF_DOUT:    rd_word[N_PINS-1:0] = dout_q;
            OFF_DIN:     rd_word[N_PINS-1:0] = sync2_q;
            OFF_RISE_EN: rd_word[N_PINS-1:0] = rise_en_q;
            OFF_FALL_EN: rd_word[N_PINS-1:0] = fall_en_q;
            OFF_STATUS:  rd_word[N_PINS-1:0] = status_q;
            OFF_PADCFG:  rd_word[PW-1:0]     = padcfg_q;
            default:     rd_word = '0;
        endcase
    end

    // Bus outputs are forced quiet while reset is asserted.
    assign prdata       = (psel & reset_int) ? rd_word : '0;
    assign pslverr      = reset_int & err;
    assign pready       = 1'b1;
    assign pad_data_out = dout_q;
    assign irq_out      = irq_q;

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            dir_q     <= '0;
            dout_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            padcfg_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_PINS; i++) begin
                settle_q[i] <= SETTLE_LOAD;
            end
        end else begin
            dir_q     <= dir_d;
            dout_q    <= dout_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            padcfg_q  <= padcfg_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            irq_q     <= irq_d;
            for (int i = 0; i < N_PINS; i++) begin
                settle_q[i] <= settle_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with hand-computed values.
module tb_gpio_pad_ctrl;

    localparam int SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [23:0] pad_cfg_out;
    logic [7:0]  pad_data_out;
    logic [7:0]  pad_in;
    logic        irq_out;

    int n_cmp = 0;
    int n_err = 0;

    gpio_pad_ctrl #(.N_PINS(8), .CONF_WIDTH(3), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_in(clk), .reset_int(rst_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .pad_cfg_out(pad_cfg_out),
        .pad_data_out(pad_data_out), .pad_data_in(pad_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_dir, m_dout, m_rise, m_fall, m_status, m_padcfg;
    logic        m_irq;
    logic [7:0]  samp [3];   // pad sampled at the last three edges, newest first
    int          age [8];    // edges spent as an input, saturating
    logic [7:0]  mset, mclr;
    int          moff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir = 0; m_dout = 0; m_rise = 0; m_fall = 0; m_status = 0; m_padcfg = 0;
            m_irq = 1'b0;
            for (int i = 0; i < 3; i++) samp[i] = 8'h00;
            for (int i = 0; i < 8; i++) age[i] = 0;
        end else begin
            mset = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (!m_dir[i] && age[i] >= SETTLE) begin
                    if (m_rise[i] && samp[1][i] && !samp[2][i]) mset[i] = 1'b1;
                    if (m_fall[i] && !samp[1][i] && samp[2][i]) mset[i] = 1'b1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (m_dir[i]) age[i] = 0;
                else if (age[i] < SETTLE) age[i] = age[i] + 1;
            end
            m_irq = (m_status != 0);
            mclr = 8'h00;
            moff = 4 * int'(paddr[4:2]);
            if (psel && penable && pwrite && !(moff > 'h18 || moff == 'h08)) begin
                case (moff)
                    'h00: m_dir    = pwdata & 32'hFF;
                    'h04: m_dout   = pwdata & 32'hFF;
                    'h0C: m_rise   = pwdata & 32'hFF;
                    'h10: m_fall   = pwdata & 32'hFF;
                    'h14: mclr     = pwdata[7:0];
                    'h18: m_padcfg = pwdata & 32'h3;
                    default: ;
                endcase
            end
            m_status = (m_status & ~{24'h0, mclr}) | {24'h0, mset};
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = pad_in;
        end
    end

    function automatic logic [31:0] exp_cfg();
        logic [31:0] r = 0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = {m_padcfg[1:0], ~m_dir[i]};
        return r;
    endfunction

    function automatic logic [31:0] exp_prdata();
        if (!rst_n || !psel) return 0;
        case (paddr[4:2])
            3'd0: return m_dir;
            3'd1: return m_dout;
            3'd2: return {24'h0, samp[1]};
            3'd3: return m_rise;
            3'd4: return m_fall;
            3'd5: return m_status;
            3'd6: return m_padcfg;
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_slverr();
        return rst_n && psel && penable && (paddr[4:2] == 3'd7 || (pwrite && paddr[4:2] == 3'd2));
    endfunction

    always @(negedge clk) begin
        chk("cmp_prdata",  prdata, exp_prdata());
        chk("cmp_pslverr", 32'(pslverr), 32'(exp_slverr()));
        chk("cmp_pready",  32'(pready), 32'h1);
        chk("cmp_cfg",     32'(pad_cfg_out), exp_cfg());
        chk("cmp_dout",    32'(pad_data_out), m_dout);
        chk("cmp_irq",     32'(irq_out), 32'(m_irq));
    end

    // ---------------- stimulus ----------------
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic e);
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #2;
        penable = 1;
        @(negedge clk); e = pslverr;
        @(posedge clk); #2;
        psel = 0; penable = 0; pwrite = 0;
        $display("APB write addr=0x%02h data=0x%08h slverr=%0d", a, d, e);
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #2;
        penable = 1;
        @(negedge clk); d = prdata; e = pslverr;
        @(posedge clk); #2;
        psel = 0; penable = 0;
        $display("APB read  addr=0x%02h data=0x%08h slverr=%0d", a, d, e);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        #1 d = prdata;
    endtask

    logic [31:0] rd;
    logic        e;
    logic [31:0] rst_vals [7];

    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pad_in = 8'h21;
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg", 32'(pad_cfg_out), 32'h249249);
        chk("rst_dout", 32'(pad_data_out), 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_slverr", 32'(pslverr), 32'h0);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);

        rst_vals = '{32'h0, 32'h0, 32'h21, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            apb_read(5'(4 * i), rd, e);
            chk("rst_read", rd, rst_vals[i]);
        end

        // Direction, data and pad config
        apb_write(5'h00, 32'hFFFF_FF0F, e);
        apb_write(5'h04, 32'h0000_0005, e);
        apb_write(5'h18, 32'h0000_00FF, e);
        #1;
        chk("cfg_dout", 32'(pad_data_out), 32'h05);
        chk("cfg_vec", 32'(pad_cfg_out), 32'hFFFDB6);
        apb_read(5'h00, rd, e); chk("dir_mask", rd, 32'h0F);
        apb_read(5'h18, rd, e); chk("padcfg_mask", rd, 32'h3);

        // Rising edge on pin 7
        apb_write(5'h0C, 32'h80, e);
        repeat (2) @(posedge clk);
        #2 pad_in[7] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            peek(5'h08, rd); chk("rise_din", rd, (c == 0) ? 32'h21 : 32'hA1);
            peek(5'h14, rd); chk("rise_status", rd, (c >= 2) ? 32'h80 : 32'h0);
            chk("rise_irq", 32'(irq_out), (c == 3) ? 32'h1 : 32'h0);
            $display("rise cycle k+%0d din=0x%02h irq=%0d", c, dut.sync2_q, irq_out);
        end
        psel = 0;

        // W1C coinciding with a new rise: the set must win
        pad_in[7] = 1'b0;
        repeat (5) @(posedge clk);
        #2 pad_in[7] = 1'b1;
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = 1; paddr = 5'h14; pwdata = 32'h80;
        @(posedge clk); #2 penable = 1;
        @(posedge clk); #2 psel = 0; penable = 0; pwrite = 0;
        @(negedge clk);
        peek(5'h14, rd); chk("w1c_race_status", rd, 32'h80);
        chk("w1c_race_irq", 32'(irq_out), 32'h1);
        psel = 0;
        repeat (3) @(posedge clk);
        apb_write(5'h14, 32'h80, e);
        @(negedge clk);
        peek(5'h14, rd); chk("w1c_status", rd, 32'h0);
        chk("w1c_irq_hold", 32'(irq_out), 32'h1);
        psel = 0;
        @(posedge clk); @(negedge clk);
        chk("w1c_irq_drop", 32'(irq_out), 32'h0);

        // Settle window after pin 2 turns into an input
        apb_write(5'h04, 32'h01, e);
        apb_write(5'h0C, 32'h04, e);
        apb_write(5'h10, 32'h04, e);
        apb_write(5'h00, 32'h0B, e);
        pad_in[2] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            peek(5'h08, rd); chk("settle_din", rd, (c >= 2) ? 32'hA5 : 32'hA1);
            peek(5'h14, rd); chk("settle_status", rd, 32'h0);
            $display("settle cycle W+%0d status=0x%02h", c, rd[7:0]);
        end
        psel = 0;
        repeat (2) @(posedge clk);
        #2 pad_in[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            peek(5'h14, rd); chk("fall_status", rd, (c >= 2) ? 32'h04 : 32'h0);
            chk("fall_irq", 32'(irq_out), (c == 3) ? 32'h1 : 32'h0);
        end
        psel = 0;

        // Rewriting DIR with the pin already an input must not restart settling
        apb_write(5'h14, 32'h04, e);
        repeat (2) @(posedge clk);
        apb_write(5'h00, 32'h0B, e);
        pad_in[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            peek(5'h14, rd); chk("keep_status", rd, (c == 3) ? 32'h04 : 32'h0);
        end
        psel = 0;

        // Error responses
        apb_write(5'h08, 32'hFF, e); chk("err_wr_din", 32'(e), 32'h1);
        apb_read(5'h1C, rd, e);      chk("err_rd_1c", 32'(e), 32'h1);
        chk("err_rd_1c_data", rd, 32'h0);
        apb_write(5'h1C, 32'hFF, e); chk("err_wr_1c", 32'(e), 32'h1);
        apb_read(5'h08, rd, e);      chk("din_after_err", rd, 32'hA5);
        chk("din_rd_ok", 32'(e), 32'h0);
        apb_read(5'h00, rd, e);      chk("dir_after_err", rd, 32'h0B);

        // Asynchronous reset in the middle of a write
        @(posedge clk); #2;
        psel = 1; penable = 0; pwrite = 1; paddr = 5'h00; pwdata = 32'hFF;
        @(posedge clk); #2 penable = 1;
        #1 rst_n = 0;
        #1;
        chk("arst_cfg", 32'(pad_cfg_out), 32'h249249);
        chk("arst_dout", 32'(pad_data_out), 32'h0);
        chk("arst_irq", 32'(irq_out), 32'h0);
        chk("arst_prdata", prdata, 32'h0);
        chk("arst_slverr", 32'(pslverr), 32'h0);
        @(posedge clk); #2 psel = 0; penable = 0; pwrite = 0;
        @(posedge clk); #2 rst_n = 1;
        repeat (3) @(posedge clk);
        apb_read(5'h00, rd, e); chk("arst_dir_lost", rd, 32'h0);
        apb_read(5'h14, rd, e); chk("arst_status", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
